lmsm_seq: RTL and testbench

- Micro-sequencer for IITB-RISC-25 multi-register transfers (LM/SM). Sits between decode and exec.
- Accepts one LM/SM instruction, stalls the front-end, and issues one single-register load/store micro-op per set bit of the 8-bit register mask.
- Exec/LSU consumes micro-ops through a valid/ready handshake. For SM, uop_reg_idx_o also drives the register-file read index.

---
 rtl/def_ex.sv | 27 ++
 rtl/lmsm_prio_enc.sv | 21 ++
 rtl/lmsm_seq.sv | 151 +++++++++++++++
 tb/tb_lmsm_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/def_ex.sv
// Shared definitions for the LM/SM micro-sequencer: opcodes, decode bit
// positions, default address step and FSM state encodings.
package def_ex;

  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  localparam int ONEHOT_LM_BIT = 0;
  localparam int ONEHOT_SM_BIT = 1;

  localparam int ADDR_STEP_DEF = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_BASEWB = 2'd2;

  typedef struct packed {
    logic       load;
    logic [2:0] ra;
  } op_ctx_t;

  // Mask bit 7 carries R0, so register idx lives at bit position 7-idx.
  function automatic logic [7:0] reg_to_mask_bit(input logic [2:0] idx);
    return 8'h80 >> idx;
  endfunction

endpackage

// File: rtl/lmsm_prio_enc.sv
// Priority encoder over an LM/SM register mask: picks the lowest-numbered
// register still pending and flags when it is the only one left.
module lmsm_prio_enc (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       valid,
  output logic       one_left
);

  // Scanning upward lets the highest set bit (lowest register) win.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) idx = 3'(7 - i);
    end
  end

  assign valid    = |mask;
  assign one_left = valid & ((mask & (mask - 8'd1)) == 8'd0);

endmodule

// File: rtl/lmsm_seq.sv
// LM/SM micro-sequencer: expands one multi-register transfer into single
// register load/store micro-ops. Optional macro LMSM_BASE_WB_EN adds a base write-back micro-op.
module lmsm_seq
  import def_ex::*;
#(
  parameter int ADDR_STEP = ADDR_STEP_DEF,
  parameter int DATA_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  input  logic [15:0]       instr_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              is_lm_i,
  input  logic              is_sm_i,
  input  logic [DATA_W-1:0] base_val_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              accept_o,
  output logic              stall_o,
  output logic              uop_valid_o,
  output logic              uop_load_o,
  output logic              uop_store_o,
  output logic [2:0]        uop_reg_idx_o,
  output logic [DATA_W-1:0] uop_addr_o,
  output logic [DATA_W-1:0] uop_pc_o,
  output logic              uop_last_o,
  output logic              done_o
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(ADDR_STEP);

  logic [1:0]        state_q;
  logic [7:0]        mask_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] pc_q;
  op_ctx_t           ctx_q;
  logic              done_q;

  logic [1:0] op_onehot;
  logic [2:0] enc_idx;
  logic       enc_valid;
  logic       enc_one_left;
  logic       issue_st;
  logic       wb_st;
  logic       opc_match;
  logic       unused_ok;

  lmsm_prio_enc u_prio_enc (
    .mask     (mask_q),
    .idx      (enc_idx),
    .valid    (enc_valid),
    .one_left (enc_one_left)
  );

  assign op_onehot = {is_sm_i, is_lm_i};
  assign issue_st  = (state_q == ST_ISSUE);
`ifdef LMSM_BASE_WB_EN
  assign wb_st     = (state_q == ST_BASEWB);
`else
  assign wb_st     = 1'b0;
`endif

  assign accept_o = (state_q == ST_IDLE) & instr_valid_i
                  & (op_onehot[ONEHOT_LM_BIT] | op_onehot[ONEHOT_SM_BIT]) & ~flush_i;
  assign stall_o  = (state_q != ST_IDLE) | accept_o;

  // Everything downstream of valid is forced to zero when idle.
  assign uop_valid_o   = issue_st | wb_st;
  assign uop_load_o    = issue_st & ctx_q.load;
  assign uop_store_o   = issue_st & ~ctx_q.load;
  assign uop_reg_idx_o = issue_st ? enc_idx : (wb_st ? ctx_q.ra : 3'd0);
  assign uop_addr_o    = uop_valid_o ? addr_q : '0;
  assign uop_pc_o      = uop_valid_o ? pc_q : '0;
`ifdef LMSM_BASE_WB_EN
  assign uop_last_o    = wb_st;
`else
  assign uop_last_o    = issue_st & enc_one_left;
`endif
  assign done_o        = done_q;

  assign opc_match = (instr_i[15:12] == OPC_LM) | (instr_i[15:12] == OPC_SM);
`ifdef LMSM_BASE_WB_EN
  assign unused_ok = ^{opc_match, instr_i[8], enc_valid};
`else
  assign unused_ok = ^{opc_match, instr_i[8], enc_valid, ctx_q.ra};
`endif

  // Flush beats everything; a handshake in the flush cycle needs no local bookkeeping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      pc_q    <= '0;
      ctx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
        mask_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_o) begin
              mask_q     <= instr_i[7:0];
              addr_q     <= base_val_i;
              pc_q       <= pc_i;
              ctx_q.load <= op_onehot[ONEHOT_LM_BIT];
              ctx_q.ra   <= instr_i[11:9];
              if (instr_i[7:0] != 8'd0) begin
                state_q <= ST_ISSUE;
              end else begin
`ifdef LMSM_BASE_WB_EN
                state_q <= ST_BASEWB;
`else
                done_q  <= 1'b1;
`endif
              end
            end
          end
          ST_ISSUE: begin
            if (ready_i) begin
              mask_q <= mask_q & ~reg_to_mask_bit(enc_idx);
              addr_q <= addr_q + STEP;
              if (enc_one_left) begin
`ifdef LMSM_BASE_WB_EN
                state_q <= ST_BASEWB;
`else
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
`endif
              end
            end
          end
`ifdef LMSM_BASE_WB_EN
          ST_BASEWB: begin
            if (ready_i) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lmsm_seq.sv
// Self-checking bench for lmsm_seq: a queue-based transaction model checked every
// cycle, plus literal expectations per directed scenario.
module tb_lmsm_seq;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        is_lm;
  logic        is_sm;
  logic [15:0] base_val;
  logic        flush;
  logic        ready;
  logic        accept;
  logic        stall;
  logic        uop_valid;
  logic        uop_load;
  logic        uop_store;
  logic [2:0]  uop_reg_idx;
  logic [15:0] uop_addr;
  logic [15:0] uop_pc;
  logic        uop_last;
  logic        done;

  lmsm_seq dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .pc_i          (pc),
    .is_lm_i       (is_lm),
    .is_sm_i       (is_sm),
    .base_val_i    (base_val),
    .flush_i       (flush),
    .ready_i       (ready),
    .accept_o      (accept),
    .stall_o       (stall),
    .uop_valid_o   (uop_valid),
    .uop_load_o    (uop_load),
    .uop_store_o   (uop_store),
    .uop_reg_idx_o (uop_reg_idx),
    .uop_addr_o    (uop_addr),
    .uop_pc_o      (uop_pc),
    .uop_last_o    (uop_last),
    .done_o        (done)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  idx;
    logic [15:0] addr;
    logic [15:0] pc;
  } uop_t;

  uop_t model_q[$];
  uop_t log_q[$];
  logic exp_done;
  int   checks;
  int   errors;
  int   cyc;
  int   done_count;
  int   valid_cycles;
  int   stall_cycles;
  int   acc_cyc;
  int   done_cyc;
  logic ready_toggle;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ready_toggle) ready = ~ready;
    else ready = 1'b1;
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference behaviour: on accept, the whole list of micro-ops is known up front.
  always @(negedge clk) begin
    uop_t h;
    uop_t a;
    logic exp_acc;
    logic nd;
    logic [15:0] ad;
    if (!rst_n) begin
      model_q.delete();
      exp_done = 1'b0;
      check_output("rst_valid", uop_valid, 0);
      check_output("rst_stall", stall, 0);
      check_output("rst_done", done, 0);
      check_output("rst_addr", uop_addr, 0);
      check_output("rst_flags", {uop_load, uop_store, uop_last, uop_reg_idx}, 0);
    end else begin
      exp_acc = (model_q.size() == 0) && instr_valid && (is_lm || is_sm) && !flush;
      check_output("accept", accept, exp_acc);
      check_output("stall", stall, (model_q.size() != 0) || exp_acc);
      check_output("uop_valid", uop_valid, model_q.size() != 0);
      check_output("done", done, exp_done);
      if (model_q.size() != 0) begin
        h = model_q[0];
        check_output("uop_load", uop_load, h.ld);
        check_output("uop_store", uop_store, h.st);
        check_output("uop_idx", uop_reg_idx, h.idx);
        check_output("uop_addr", uop_addr, h.addr);
        check_output("uop_pc", uop_pc, h.pc);
        check_output("uop_last", uop_last, model_q.size() == 1);
      end
      if (done) begin done_count++; done_cyc = cyc; end
      if (accept) acc_cyc = cyc;
      if (uop_valid) valid_cycles++;
      if (stall) stall_cycles++;
      if (uop_valid && ready) begin
        a.ld = uop_load; a.st = uop_store; a.idx = uop_reg_idx;
        a.addr = uop_addr; a.pc = uop_pc;
        log_q.push_back(a);
      end
      nd = 1'b0;
      if (flush) begin
        model_q.delete();
      end else if (model_q.size() != 0) begin
        if (ready) begin
          void'(model_q.pop_front());
          if (model_q.size() == 0) nd = 1'b1;
        end
      end else if (exp_acc) begin
        ad = base_val;
        for (int r = 0; r < 8; r++) begin
          if (instr[7 - r]) begin
            h.ld = is_lm; h.st = !is_lm; h.idx = 3'(r); h.addr = ad; h.pc = pc;
            model_q.push_back(h);
            ad = ad + 16'd2;
          end
        end
`ifdef LMSM_BASE_WB_EN
        h.ld = 1'b0; h.st = 1'b0; h.idx = instr[11:9]; h.addr = ad; h.pc = pc;
        model_q.push_back(h);
`endif
        if (model_q.size() == 0) nd = 1'b1;
      end
      exp_done = nd;
    end
  end

  task automatic apply_stimulus(input logic lm, input logic sm, input logic [2:0] ra,
                                input logic [7:0] mask, input logic [15:0] base,
                                input logic [15:0] ipc);
    instr_valid = 1'b1;
    is_lm = lm;
    is_sm = sm;
    instr = {(lm ? 4'b0110 : 4'b0111), ra, 1'b0, mask};
    base_val = base;
    pc = ipc;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    is_lm = 1'b0;
    is_sm = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((model_q.size() != 0 || exp_done) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: got timeout expected idle within 200 cycles");
    end
  endtask

  task automatic clear_stats();
    log_q.delete();
    done_count = 0;
    valid_cycles = 0;
    stall_cycles = 0;
  endtask

  task automatic check_entry(input string name, input int n, input logic ld, input logic st,
                             input logic [2:0] idx, input logic [15:0] addr);
    if (n >= log_q.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0d handshakes expected entry %0d", name, log_q.size(), n);
    end else begin
      check_output({name, ".kind"}, {log_q[n].ld, log_q[n].st}, {ld, st});
      check_output({name, ".idx"}, log_q[n].idx, idx);
      check_output({name, ".addr"}, log_q[n].addr, addr);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0;
    is_lm = 1'b0; is_sm = 1'b0; base_val = '0; flush = 1'b0;
    ready = 1'b1; ready_toggle = 1'b0; exp_done = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single-bit LM");
    clear_stats();
    apply_stimulus(1'b1, 1'b0, 3'd3, 8'b0000_0001, 16'h2000, 16'h0100);
    wait_idle();
    check_entry("t1_r7", 0, 1'b1, 1'b0, 3'd7, 16'h2000);
`ifdef LMSM_BASE_WB_EN
    check_entry("t1_wb", 1, 1'b0, 1'b0, 3'd3, 16'h2002);
    check_output("t1_done_lat", done_cyc - acc_cyc, 3);
`else
    check_output("t1_count", log_q.size(), 1);
    check_output("t1_done_lat", done_cyc - acc_cyc, 2);
`endif
    check_output("t1_done_cnt", done_count, 1);

    $display("[TB] SM three registers");
    clear_stats();
    apply_stimulus(1'b0, 1'b1, 3'd1, 8'b1010_0001, 16'h4000, 16'h0200);
    wait_idle();
    check_entry("t2_r0", 0, 1'b0, 1'b1, 3'd0, 16'h4000);
    check_entry("t2_r2", 1, 1'b0, 1'b1, 3'd2, 16'h4002);
    check_entry("t2_r7", 2, 1'b0, 1'b1, 3'd7, 16'h4004);
    check_output("t2_done_cnt", done_count, 1);

    $display("[TB] backpressure LM full mask");
    clear_stats();
    ready_toggle = 1'b1;
    apply_stimulus(1'b1, 1'b0, 3'd2, 8'hFF, 16'h2000, 16'h0300);
    wait_idle();
    ready_toggle = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      check_entry("t3_seq", i, 1'b1, 1'b0, 3'(i), 16'h2000 + 16'(2 * i));
    end
    check_output("t3_done_cnt", done_count, 1);

    $display("[TB] zero mask");
    clear_stats();
    apply_stimulus(1'b1, 1'b0, 3'd1, 8'h00, 16'h3000, 16'h0400);
    wait_idle();
    check_output("t4_done_cnt", done_count, 1);
`ifdef LMSM_BASE_WB_EN
    check_entry("t4_wb", 0, 1'b0, 1'b0, 3'd1, 16'h3000);
`else
    check_output("t4_valid_cycles", valid_cycles, 0);
    check_output("t4_stall_cycles", stall_cycles, 1);
`endif

    $display("[TB] flush mid-sequence");
    clear_stats();
    apply_stimulus(1'b1, 1'b0, 3'd4, 8'hFF, 16'h2000, 16'h0500);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_output("t5_hs_count", log_q.size(), 3);
    check_output("t5_no_done", done_count, 0);
    apply_stimulus(1'b1, 1'b0, 3'd6, 8'b0010_0000, 16'h5000, 16'h0600);
    wait_idle();
    check_entry("t5_new", 3, 1'b1, 1'b0, 3'd2, 16'h5000);
    check_output("t5_done_cnt", done_count, 1);

    $display("[TB] address wrap");
    clear_stats();
    apply_stimulus(1'b1, 1'b0, 3'd5, 8'b1100_0000, 16'hFFFE, 16'h0700);
    wait_idle();
    check_entry("t6_r0", 0, 1'b1, 1'b0, 3'd0, 16'hFFFE);
    check_entry("t6_r1", 1, 1'b1, 1'b0, 3'd1, 16'h0000);
`ifdef LMSM_BASE_WB_EN
    check_entry("t6_wb", 2, 1'b0, 1'b0, 3'd5, 16'h0002);
`endif

    $display("[TB] reset mid-operation");
    clear_stats();
    apply_stimulus(1'b1, 1'b0, 3'd0, 8'hFF, 16'h6000, 16'h0800);
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("t7_no_done", done_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
